// File: rtl/triangle_raster_scan_controller.sv
// triangle_raster_scan_controller
// Walks a triangle's clamped screen bounding box in row-major order. Each
// (x,y) is driven to a combinational pixel unit. Covered pixels are handed to
// the framebuffer writer over a valid/ready handshake.
// Optional feature macro: RASTER_PIXEL_COUNT_EN builds the covered-pixel
// counter on o_pix_count. When the macro is not defined, o_pix_count is tied to 0.

package raster_pkg;
    // Signed 16.16 fixed point
    typedef logic signed [31:0] FixedPoint_t;

    typedef struct packed {
        FixedPoint_t x;
        FixedPoint_t y;
        FixedPoint_t z;
        FixedPoint_t w;
    } Vector4_t;
endpackage

module triangle_raster_scan_controller
    import raster_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  Vector4_t           i_v1,
    input  Vector4_t           i_v2,
    input  Vector4_t           i_v3,
    input  Vector4_t           i_c1,
    input  Vector4_t           i_c2,
    input  Vector4_t           i_c3,
    output Vector4_t           o_v1,
    output Vector4_t           o_v2,
    output Vector4_t           o_v3,
    output Vector4_t           o_c1,
    output Vector4_t           o_c2,
    output Vector4_t           o_c3,
    output logic signed [31:0] o_pix_x,
    output logic signed [31:0] o_pix_y,
    input  logic               i_pix_write,
    input  Vector4_t           i_pix_colour,
    output logic               o_fb_valid,
    input  logic               i_fb_ready,
    output logic signed [31:0] o_fb_x,
    output logic signed [31:0] o_fb_y,
    output Vector4_t           o_fb_colour,
    output logic               o_busy,
    output logic               o_done,
    output logic [31:0]        o_pix_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SCAN,
        S_EMIT,
        S_DONE
    } state_t;

    state_t             r_state;
    Vector4_t           r_v1, r_v2, r_v3, r_c1, r_c2, r_c3;
    logic signed [31:0] r_min_x, r_max_x, r_max_y;
    logic signed [31:0] r_pix_x, r_pix_y;
    logic signed [31:0] r_fb_x, r_fb_y;
    Vector4_t           r_fb_colour;
    logic               r_fb_valid, r_busy, r_done;

    function automatic FixedPoint_t min3(input FixedPoint_t a, input FixedPoint_t b,
                                         input FixedPoint_t c);
        FixedPoint_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic FixedPoint_t max3(input FixedPoint_t a, input FixedPoint_t b,
                                         input FixedPoint_t c);
        FixedPoint_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Arithmetic shift gives the floor, which is also correct for negative coordinates
    logic signed [31:0] w_raw_min_x, w_raw_max_x, w_raw_min_y, w_raw_max_y;
    assign w_raw_min_x = min3(r_v1.x, r_v2.x, r_v3.x) >>> 16;
    assign w_raw_max_x = max3(r_v1.x, r_v2.x, r_v3.x) >>> 16;
    assign w_raw_min_y = min3(r_v1.y, r_v2.y, r_v3.y) >>> 16;
    assign w_raw_max_y = max3(r_v1.y, r_v2.y, r_v3.y) >>> 16;

    // Clamp the bounds to the screen. The box is empty when no part of it lies
    // on the screen. Clamped lower bounds never exceed the screen edge, so o_pix_x/y stay legal.
    logic signed [31:0] w_lo_x, w_hi_x, w_lo_y, w_hi_y;
    logic               w_box_empty;
    assign w_lo_x = (w_raw_min_x < 0) ? 32'sd0 :
                    (w_raw_min_x > SCREEN_WIDTH - 1) ? 32'(SCREEN_WIDTH - 1) : w_raw_min_x;
    assign w_hi_x = (w_raw_max_x > SCREEN_WIDTH - 1) ? 32'(SCREEN_WIDTH - 1) :
                    (w_raw_max_x < 0) ? 32'sd0 : w_raw_max_x;
    assign w_lo_y = (w_raw_min_y < 0) ? 32'sd0 :
                    (w_raw_min_y > SCREEN_HEIGHT - 1) ? 32'(SCREEN_HEIGHT - 1) : w_raw_min_y;
    assign w_hi_y = (w_raw_max_y > SCREEN_HEIGHT - 1) ? 32'(SCREEN_HEIGHT - 1) :
                    (w_raw_max_y < 0) ? 32'sd0 : w_raw_max_y;
    assign w_box_empty = (w_raw_max_x < 0) || (w_raw_min_x > SCREEN_WIDTH - 1) ||
                         (w_raw_max_y < 0) || (w_raw_min_y > SCREEN_HEIGHT - 1);

    // Next coordinate in row-major order. SCAN and EMIT share this logic.
    logic signed [31:0] w_next_x, w_next_y;
    logic               w_scan_end;
    always_comb begin
        w_next_x   = r_pix_x;
        w_next_y   = r_pix_y;
        w_scan_end = 1'b0;
        if (r_pix_x < r_max_x) begin
            w_next_x = r_pix_x + 32'sd1;
        end else if (r_pix_y < r_max_y) begin
            w_next_x = r_min_x;
            w_next_y = r_pix_y + 32'sd1;
        end else begin
            w_scan_end = 1'b1;
        end
    end

    // Control FSM with registered handshake and status outputs
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_v1        <= '0;
            r_v2        <= '0;
            r_v3        <= '0;
            r_c1        <= '0;
            r_c2        <= '0;
            r_c3        <= '0;
            r_min_x     <= '0;
            r_max_x     <= '0;
            r_max_y     <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_fb_x      <= '0;
            r_fb_y      <= '0;
            r_fb_colour <= '0;
            r_fb_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_v1    <= i_v1;
                        r_v2    <= i_v2;
                        r_v3    <= i_v3;
                        r_c1    <= i_c1;
                        r_c2    <= i_c2;
                        r_c3    <= i_c3;
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_min_x <= w_lo_x;
                    r_max_x <= w_hi_x;
                    r_max_y <= w_hi_y;
                    r_pix_x <= w_lo_x;
                    r_pix_y <= w_lo_y;
                    if (w_box_empty) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (i_pix_write) begin
                        r_fb_x      <= r_pix_x;
                        r_fb_y      <= r_pix_y;
                        r_fb_colour <= i_pix_colour;
                        r_fb_valid  <= 1'b1;
                        r_state     <= S_EMIT;
                    end else begin
                        r_pix_x <= w_next_x;
                        r_pix_y <= w_next_y;
                        if (w_scan_end) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_EMIT: begin
                    if (i_fb_ready) begin
                        r_fb_valid <= 1'b0;
                        r_pix_x    <= w_next_x;
                        r_pix_y    <= w_next_y;
                        if (w_scan_end) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef RASTER_PIXEL_COUNT_EN
    logic [31:0] r_pix_count;

    // Count accepted framebuffer writes for the current triangle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pix_count <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_pix_count <= '0;
        end else if (r_fb_valid && i_fb_ready) begin
            r_pix_count <= r_pix_count + 32'd1;
        end
    end

    assign o_pix_count = r_pix_count;
`else
    assign o_pix_count = '0;
`endif

    assign o_v1        = r_v1;
    assign o_v2        = r_v2;
    assign o_v3        = r_v3;
    assign o_c1        = r_c1;
    assign o_c2        = r_c2;
    assign o_c3        = r_c3;
    assign o_pix_x     = r_pix_x;
    assign o_pix_y     = r_pix_y;
    assign o_fb_valid  = r_fb_valid;
    assign o_fb_x      = r_fb_x;
    assign o_fb_y      = r_fb_y;
    assign o_fb_colour = r_fb_colour;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_triangle_raster_scan_controller.sv
// Testbench for triangle_raster_scan_controller.
// The bench includes a behavioural pixel unit. A scoreboard holds the
// framebuffer writes that the bench itself predicts from the triangle bounds
// and the coverage model.

module tb_triangle_raster_scan_controller;
    import raster_pkg::*;

    localparam int W = 640;
    localparam int H = 480;

    logic               i_clk = 1'b0;
    logic               i_reset, i_start, i_pix_write, i_fb_ready;
    Vector4_t           i_v1, i_v2, i_v3, i_c1, i_c2, i_c3, i_pix_colour;
    Vector4_t           o_v1, o_v2, o_v3, o_c1, o_c2, o_c3, o_fb_colour;
    logic signed [31:0] o_pix_x, o_pix_y, o_fb_x, o_fb_y;
    logic               o_fb_valid, o_busy, o_done;
    logic [31:0]        o_pix_count;

    triangle_raster_scan_controller #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .i_v1(i_v1), .i_v2(i_v2), .i_v3(i_v3),
        .i_c1(i_c1), .i_c2(i_c2), .i_c3(i_c3),
        .o_v1(o_v1), .o_v2(o_v2), .o_v3(o_v3),
        .o_c1(o_c1), .o_c2(o_c2), .o_c3(o_c3),
        .o_pix_x(o_pix_x), .o_pix_y(o_pix_y),
        .i_pix_write(i_pix_write), .i_pix_colour(i_pix_colour),
        .o_fb_valid(o_fb_valid), .i_fb_ready(i_fb_ready),
        .o_fb_x(o_fb_x), .o_fb_y(o_fb_y), .o_fb_colour(o_fb_colour),
        .o_busy(o_busy), .o_done(o_done), .o_pix_count(o_pix_count)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Pixel unit model. Mode 0 covers every pixel. Mode 1 covers the pixels
    // whose centres lie inside (0,0),(4,0),(0,4). Any other mode covers no pixel.
    int mode = 0;

    function automatic logic covered(input int m, input int x, input int y);
        case (m)
            0:       return 1'b1;
            1:       return (x >= 0) && (y >= 0) && (x + y <= 3);
            default: return 1'b0;
        endcase
    endfunction

    function automatic Vector4_t pix_colour(input int x, input int y);
        Vector4_t c;
        c.x = FixedPoint_t'(x) <<< 16;
        c.y = FixedPoint_t'(y) <<< 16;
        c.z = 32'sh00ff_0000 ^ FixedPoint_t'(x * 7 + y);
        c.w = 32'sh0001_0000;
        return c;
    endfunction

    always_comb begin
        i_pix_write  = covered(mode, o_pix_x, o_pix_y);
        i_pix_colour = pix_colour(o_pix_x, o_pix_y);
    end

    function automatic FixedPoint_t fx(input int whole, input int frac);
        return (FixedPoint_t'(whole) <<< 16) + FixedPoint_t'(frac);
    endfunction

    typedef struct {
        int       x;
        int       y;
        Vector4_t c;
    } wr_t;

    wr_t sb[$];

    // Runs one triangle. Predicted writes go into the scoreboard and are
    // compared as the DUT hands them over. bp = number of cycles that ready is
    // held low on the first write. exp_lat < 0 skips the start-to-done latency
    // check. poke = pulse i_start while busy, which the DUT must ignore.
    task automatic run_tri(input string name,
                           input FixedPoint_t ax, input FixedPoint_t ay,
                           input FixedPoint_t bx, input FixedPoint_t by,
                           input FixedPoint_t cx, input FixedPoint_t cy,
                           input int m, input int bp, input int exp_lat, input bit poke);
        int  rmin_x, rmax_x, rmin_y, rmax_y, lo_x, hi_x, lo_y, hi_y;
        int  exp_writes, writes, bp_left, lat, max_px;
        bit  done, off, busy_at_done;
        wr_t e;

        rmin_x = ((ax < bx ? ax : bx) < cx ? (ax < bx ? ax : bx) : cx) >>> 16;
        rmax_x = ((ax > bx ? ax : bx) > cx ? (ax > bx ? ax : bx) : cx) >>> 16;
        rmin_y = ((ay < by ? ay : by) < cy ? (ay < by ? ay : by) : cy) >>> 16;
        rmax_y = ((ay > by ? ay : by) > cy ? (ay > by ? ay : by) : cy) >>> 16;
        off  = (rmax_x < 0) || (rmin_x > W - 1) || (rmax_y < 0) || (rmin_y > H - 1);
        lo_x = (rmin_x < 0) ? 0 : rmin_x;
        hi_x = (rmax_x > W - 1) ? W - 1 : rmax_x;
        lo_y = (rmin_y < 0) ? 0 : rmin_y;
        hi_y = (rmax_y > H - 1) ? H - 1 : rmax_y;

        sb.delete();
        if (!off) begin
            for (int y = lo_y; y <= hi_y; y++) begin
                for (int x = lo_x; x <= hi_x; x++) begin
                    if (covered(m, x, y)) begin
                        e.x = x;
                        e.y = y;
                        e.c = pix_colour(x, y);
                        sb.push_back(e);
                    end
                end
            end
        end
        exp_writes = sb.size();

        mode         = m;
        writes       = 0;
        bp_left      = bp;
        lat          = 0;
        max_px       = -1;
        done         = 1'b0;
        busy_at_done = 1'b0;
        i_fb_ready   = 1'b1;
        i_v1 = '{x: ax, y: ay, z: 32'sd0, w: 32'sh0001_0000};
        i_v2 = '{x: bx, y: by, z: 32'sd0, w: 32'sh0001_0000};
        i_v3 = '{x: cx, y: cy, z: 32'sd0, w: 32'sh0001_0000};
        i_c1 = '{x: 32'sh0001_0000, y: 32'sd0, z: 32'sd0, w: 32'sh0001_0000};
        i_c2 = '{x: 32'sd0, y: 32'sh0001_0000, z: 32'sd0, w: 32'sh0001_0000};
        i_c3 = '{x: 32'sd0, y: 32'sd0, z: 32'sh0001_0000, w: 32'sh0001_0000};
        i_start = 1'b1;

        for (int cyc = 1; cyc <= 20000 && !done; cyc++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            i_start = 1'b0;
            if (poke && cyc == 5) begin
                i_start = 1'b1;
                i_v1.x  = fx(100, 0);
            end
            if (o_pix_x > max_px) max_px = o_pix_x;
            if (o_fb_valid) begin
                if (sb.size() == 0) begin
                    check({name, "_unexpected_write"}, 32'(o_fb_valid), 32'd0);
                    i_fb_ready = 1'b1;
                end else if (bp_left > 0) begin
                    check({name, "_bp_fb_x"}, o_fb_x, sb[0].x);
                    check({name, "_bp_fb_y"}, o_fb_y, sb[0].y);
                    check({name, "_bp_colour_z"}, o_fb_colour.z, sb[0].c.z);
                    check({name, "_bp_pix_x_hold"}, o_pix_x, sb[0].x);
                    bp_left--;
                    i_fb_ready = 1'b0;
                end else begin
                    i_fb_ready = 1'b1;
                    check({name, "_fb_x"}, o_fb_x, sb[0].x);
                    check({name, "_fb_y"}, o_fb_y, sb[0].y);
                    check({name, "_colour_x"}, o_fb_colour.x, sb[0].c.x);
                    check({name, "_colour_z"}, o_fb_colour.z, sb[0].c.z);
                    void'(sb.pop_front());
                    writes++;
                end
            end
            if (o_done) begin
                done         = 1'b1;
                lat          = cyc;
                busy_at_done = o_busy;
            end
        end

        check({name, "_done_seen"}, 32'(done), 32'd1);
        if (exp_lat >= 0) check({name, "_latency"}, lat, exp_lat);
        check({name, "_writes"}, writes, exp_writes);
        check({name, "_sb_left"}, sb.size(), 0);
        check({name, "_busy_in_done"}, 32'(busy_at_done), 32'd1);
        check({name, "_max_pix_x_on_screen"}, 32'(max_px > W - 1), 32'd0);
`ifdef RASTER_PIXEL_COUNT_EN
        check({name, "_pix_count"}, o_pix_count, exp_writes);
`else
        check({name, "_pix_count"}, o_pix_count, 32'd0);
`endif
        check({name, "_v1_x_latched"}, o_v1.x, ax);
        @(posedge i_clk);
        @(negedge i_clk);
        check({name, "_done_pulse"}, 32'(o_done), 32'd0);
        check({name, "_idle_after"}, 32'(o_busy), 32'd0);
    endtask

    task automatic reset_in_emit();
        bit seen;
        seen       = 1'b0;
        mode       = 0;
        i_fb_ready = 1'b0;
        i_v1 = '{x: fx(0, 0), y: fx(0, 0), z: 32'sd0, w: 32'sd0};
        i_v2 = '{x: fx(4, 0), y: fx(0, 0), z: 32'sd0, w: 32'sd0};
        i_v3 = '{x: fx(0, 0), y: fx(4, 0), z: 32'sd0, w: 32'sd0};
        i_start = 1'b1;
        for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            i_start = 1'b0;
            if (o_fb_valid) seen = 1'b1;
        end
        check("rst_emit_valid_seen", 32'(seen), 32'd1);
        check("rst_emit_busy_before", 32'(o_busy), 32'd1);
        i_reset = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        check("rst_emit_fb_valid", 32'(o_fb_valid), 32'd0);
        check("rst_emit_busy", 32'(o_busy), 32'd0);
        check("rst_emit_fb_x", o_fb_x, 32'd0);
        check("rst_emit_v2_x", o_v2.x, 32'd0);
        i_reset    = 1'b0;
        i_fb_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        check("rst_emit_stay_idle", 32'(o_busy), 32'd0);
    endtask

    initial begin
        i_reset    = 1'b1;
        i_start    = 1'b0;
        i_fb_ready = 1'b1;
        i_v1 = '0; i_v2 = '0; i_v3 = '0;
        i_c1 = '0; i_c2 = '0; i_c3 = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_done", 32'(o_done), 32'd0);
        check("reset_fb_valid", 32'(o_fb_valid), 32'd0);
        check("reset_pix_count", o_pix_count, 32'd0);
        check("reset_pix_x", o_pix_x, 32'd0);
        check("reset_fb_y", o_fb_y, 32'd0);
        check("reset_v1_x", o_v1.x, 32'd0);
        i_reset = 1'b0;
        @(negedge i_clk);

        run_tri("single", fx(2, 32768), fx(3, 32768), fx(2, 39322), fx(3, 32768),
                fx(2, 32768), fx(3, 39322), 0, 0, 4, 1'b0);
        run_tri("right", fx(0, 0), fx(0, 0), fx(4, 0), fx(0, 0),
                fx(0, 0), fx(4, 0), 1, 0, -1, 1'b1);
        run_tri("backpressure", fx(0, 0), fx(0, 0), fx(4, 0), fx(0, 0),
                fx(0, 0), fx(4, 0), 1, 5, -1, 1'b0);
        run_tri("offscreen", fx(-10, 0), fx(0, 0), fx(-5, 0), fx(3, 0),
                fx(-8, 0), fx(5, 0), 0, 0, 2, 1'b0);
        run_tri("clamp", fx(600, 0), fx(0, 0), fx(700, 0), fx(0, 0),
                fx(600, 0), fx(1, 0), 0, 0, -1, 1'b0);
        reset_in_emit();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
